// File: rtl/servile_pkg.sv
// Shared definitions for the servile bus arbiter: state encodings, counter width
// and the downstream write-side payload.
package servile_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IBUS = 2'd1;
  localparam logic [1:0] ST_DBUS = 2'd2;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wb_wr_t;

  localparam wb_wr_t WB_WR_IDLE = '{dat: 32'h0, sel: 4'h0, we: 1'b0};
  localparam wb_wr_t WB_WR_IBUS = '{dat: 32'h0, sel: 4'hF, we: 1'b0};

  // Round-robin pick from IDLE; last_i=1 means ibus was served last, so dbus wins a tie.
  function automatic logic [1:0] arb_pick(input logic ibus_cyc,
                                          input logic dbus_cyc,
                                          input logic last_i);
    logic [1:0] pick;
    pick = ST_IDLE;
    if (ibus_cyc && dbus_cyc) begin
      pick = last_i ? ST_DBUS : ST_IBUS;
    end else if (ibus_cyc) begin
      pick = ST_IBUS;
    end else if (dbus_cyc) begin
      pick = ST_DBUS;
    end
    return pick;
  endfunction

endpackage

// File: rtl/servile_bus_arb_if.sv
// Bundle of the ibus, dbus and downstream SRAM/RF signals around the arbiter.
// slave = the arbiter's view; master = the surrounding masters and memory.
interface servile_bus_arb_if #(
  parameter int unsigned aw = 8
) ();

  logic [aw-3:0] i_ibus_adr;
  logic          i_ibus_cyc;
  logic [31:0]   o_ibus_rdt;
  logic          o_ibus_ack;

  logic [aw-3:0] i_dbus_adr;
  logic [31:0]   i_dbus_dat;
  logic [3:0]    i_dbus_sel;
  logic          i_dbus_we;
  logic          i_dbus_cyc;
  logic [31:0]   o_dbus_rdt;
  logic          o_dbus_ack;

  logic [aw-3:0] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we;
  logic          o_wb_stb;
  logic [31:0]   i_wb_rdt;
  logic          i_wb_ack;

  logic          o_err;

  modport slave (
    input  i_ibus_adr, i_ibus_cyc,
    output o_ibus_rdt, o_ibus_ack,
    input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    output o_dbus_rdt, o_dbus_ack,
    output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb,
    input  i_wb_rdt, i_wb_ack,
    output o_err
  );

  modport master (
    output i_ibus_adr, i_ibus_cyc,
    input  o_ibus_rdt, o_ibus_ack,
    output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    input  o_dbus_rdt, o_dbus_ack,
    input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb,
    output i_wb_rdt, i_wb_ack,
    input  o_err
  );

endinterface

// File: rtl/servile_wait_cnt.sv
// Grant wait counter: cleared while idle, counts unacked granted cycles and flags
// the terminal value.
module servile_wait_cnt
  import servile_pkg::*;
#(
  parameter int unsigned terminal = 63
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == CNT_W'(terminal));

endmodule

// File: rtl/servile_bus_arb.sv
// Round-robin arbiter sharing one SRAM/RF port between the ibus and dbus masters,
// with a wait timeout that completes a stuck grant with zero data and an error pulse.
module servile_bus_arb
  import servile_pkg::*;
#(
  parameter int unsigned aw      = 8,
  parameter int unsigned timeout = 64
) (
  input logic              i_clk,
  input logic              i_rst,
  servile_bus_arb_if.slave bus
);

  if (timeout < 8 || timeout > 65535) begin : g_bad_timeout
    $error("servile_bus_arb: timeout out of range 8..65535");
  end

  logic [1:0]    state_q, state_d;
  logic          last_i_q, last_i_d;
  logic          granted;
  logic          tc;
  logic          wb_ack_g;
  logic          to_ack;
  logic          done;
  logic          in_ibus;
  logic          in_dbus;
  logic [aw-3:0] wb_adr;
  wb_wr_t        wb_wr;

  assign granted  = (state_q != ST_IDLE);
  assign in_ibus  = (state_q == ST_IBUS);
  assign in_dbus  = (state_q == ST_DBUS);
  assign wb_ack_g = granted & bus.i_wb_ack;
  // A real ack in the terminal cycle wins over the timeout.
  assign to_ack   = granted & tc & ~bus.i_wb_ack;
  assign done     = wb_ack_g | to_ack;

  servile_wait_cnt #(
    .terminal(timeout - 1)
  ) u_wait_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (~granted),
    .i_en  (granted & ~bus.i_wb_ack),
    .o_tc  (tc)
  );

  // Next-state and round-robin flag
  always_comb begin
    state_d  = state_q;
    last_i_d = last_i_q;
    case (state_q)
      ST_IDLE: begin
        state_d = arb_pick(bus.i_ibus_cyc, bus.i_dbus_cyc, last_i_q);
      end
      ST_IBUS: begin
        if (done) begin
          state_d  = ST_IDLE;
          last_i_d = 1'b1;
        end
      end
      ST_DBUS: begin
        if (done) begin
          state_d  = ST_IDLE;
          last_i_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      last_i_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_i_q <= last_i_d;
    end
  end

  // Downstream request mux; all-zero while idle
  always_comb begin
    wb_adr = '0;
    wb_wr  = WB_WR_IDLE;
    if (in_ibus) begin
      wb_adr = bus.i_ibus_adr;
      wb_wr  = WB_WR_IBUS;
    end else if (in_dbus) begin
      wb_adr = bus.i_dbus_adr;
      wb_wr  = '{dat: bus.i_dbus_dat, sel: bus.i_dbus_sel, we: bus.i_dbus_we};
    end
  end

  assign bus.o_wb_adr = wb_adr;
  assign bus.o_wb_dat = wb_wr.dat;
  assign bus.o_wb_sel = wb_wr.sel;
  assign bus.o_wb_we  = wb_wr.we;

  // Handshake outputs are masked during reset so an interrupted grant never completes.
  assign bus.o_wb_stb   = granted & ~i_rst;
  assign bus.o_ibus_ack = in_ibus & done & ~i_rst;
  assign bus.o_dbus_ack = in_dbus & done & ~i_rst;
  assign bus.o_err      = to_ack & ~i_rst;

  assign bus.o_ibus_rdt = (in_ibus && to_ack) ? 32'h0 : bus.i_wb_rdt;
  assign bus.o_dbus_rdt = (in_dbus && to_ack) ? 32'h0 : bus.i_wb_rdt;

endmodule

// File: tb/tb_servile_bus_arb.sv
// Scoreboard bench for servile_bus_arb: directed ibus/dbus transactions, a
// programmable memory slave, and a negedge monitor checking grants and responses.
module tb_servile_bus_arb;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 8;

  typedef struct {
    logic [5:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } grant_t;

  typedef struct {
    logic        ibus;
    logic [31:0] rdt;
    logic        err;
  } resp_t;

  typedef struct {
    int          delay;
    logic [31:0] rdt;
  } slv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  servile_bus_arb_if #(.aw(AW)) bus ();

  servile_bus_arb #(
    .aw      (AW),
    .timeout (TMO)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  grant_t gq[$];
  resp_t  rq[$];
  slv_t   slave_q[$];
  int     n_chk  = 0;
  int     n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Memory slave: acks on grant cycle 'delay' (0 = never), otherwise returns junk data
  slv_t cur;
  bit   in_grant;
  int   gcyc;
  initial begin
    bus.i_wb_ack = 1'b0;
    bus.i_wb_rdt = 32'hDEAD_BEEF;
    in_grant     = 1'b0;
    gcyc         = 0;
    cur          = '{delay: 1, rdt: 32'h0};
    forever begin
      @(posedge clk);
      #2;
      bus.i_wb_ack = 1'b0;
      bus.i_wb_rdt = 32'hDEAD_BEEF;
      if (bus.o_wb_stb) begin
        if (!in_grant) begin
          in_grant = 1'b1;
          gcyc     = 1;
          if (slave_q.size() > 0) cur = slave_q.pop_front();
          else cur = '{delay: 1, rdt: 32'h0};
        end else begin
          gcyc++;
        end
        if (cur.delay != 0 && gcyc == cur.delay) begin
          bus.i_wb_ack = 1'b1;
          bus.i_wb_rdt = cur.rdt;
        end
      end else begin
        in_grant = 1'b0;
      end
    end
  end

  // Monitor: downstream bus against the expected grant, acks against the response queue
  resp_t mon_r;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_wb_stb) begin
        if (gq.size() == 0) begin
          check("unexpected_stb", 64'(bus.o_wb_stb), 64'(0));
        end else begin
          check("wb_adr", 64'(bus.o_wb_adr), 64'(gq[0].adr));
          check("wb_dat", 64'(bus.o_wb_dat), 64'(gq[0].dat));
          check("wb_sel", 64'(bus.o_wb_sel), 64'(gq[0].sel));
          check("wb_we",  64'(bus.o_wb_we),  64'(gq[0].we));
        end
      end else begin
        check("idle_bus_zero",
              64'({bus.o_wb_adr, bus.o_wb_dat, bus.o_wb_sel, bus.o_wb_we}), 64'(0));
      end
      if (bus.o_ibus_ack || bus.o_dbus_ack) begin
        if (rq.size() == 0) begin
          check("unexpected_ack", 64'({bus.o_ibus_ack, bus.o_dbus_ack}), 64'(0));
        end else begin
          mon_r = rq.pop_front();
          check("ack_owner", 64'({bus.o_ibus_ack, bus.o_dbus_ack}),
                64'({mon_r.ibus, ~mon_r.ibus}));
          check("ack_rdt", 64'(mon_r.ibus ? bus.o_ibus_rdt : bus.o_dbus_rdt), 64'(mon_r.rdt));
          check("ack_err", 64'(bus.o_err), 64'(mon_r.err));
        end
        if (gq.size() > 0) void'(gq.pop_front());
      end else if (bus.o_err) begin
        check("err_without_ack", 64'(bus.o_err), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input bit is_ibus, input logic [5:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we, input int delay,
                            input logic [31:0] srdt, input logic [31:0] rrdt, input logic err);
    gq.push_back('{adr: adr, dat: dat, sel: sel, we: we});
    slave_q.push_back('{delay: delay, rdt: srdt});
    if (delay != 0 || err) rq.push_back('{ibus: is_ibus, rdt: rrdt, err: err});
  endtask

  task automatic set_dbus(input logic [5:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic we, input logic cyc);
    bus.i_dbus_adr = adr;
    bus.i_dbus_dat = dat;
    bus.i_dbus_sel = sel;
    bus.i_dbus_we  = we;
    bus.i_dbus_cyc = cyc;
  endtask

  // Counts cycles (this one included) until the chosen master sees ack; returns just after the next edge
  task automatic wait_ack(input bit is_dbus, input string name, input int exp_cycles);
    int cycles;
    bit got;
    cycles = 0;
    got    = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      #2;
      if (is_dbus ? bus.o_dbus_ack : bus.o_ibus_ack) begin
        got    = 1'b1;
        cycles = i;
      end
      tick();
    end
    check({name, "_ack_seen"}, 64'(got), 64'(1));
    check({name, "_ack_cycles"}, 64'(cycles), 64'(exp_cycles));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_ibus_adr = '0;
    bus.i_ibus_cyc = 1'b0;
    set_dbus(6'h00, 32'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    #2;
    check("rst_stb",  64'(bus.o_wb_stb),   64'(0));
    check("rst_iack", 64'(bus.o_ibus_ack), 64'(0));
    check("rst_dack", 64'(bus.o_dbus_ack), 64'(0));
    check("rst_err",  64'(bus.o_err),      64'(0));
    tick();
    rst = 1'b0;
    #2;
    check("idle_stb", 64'(bus.o_wb_stb), 64'(0));
    tick();

    // ibus read of 0x05, slave acks on grant cycle 5
    expect_txn(1'b1, 6'h05, 32'h0, 4'hF, 1'b0, 5, 32'h1234_5678, 32'h1234_5678, 1'b0);
    bus.i_ibus_adr = 6'h05;
    bus.i_ibus_cyc = 1'b1;
    #2;
    check("t1_stb_pre", 64'(bus.o_wb_stb), 64'(0));
    tick();
    #2;
    check("t1_stb_lat", 64'(bus.o_wb_stb), 64'(1));
    wait_ack(1'b0, "t1", 5);
    bus.i_ibus_cyc = 1'b0;
    #2;
    check("t1_stb_after", 64'(bus.o_wb_stb), 64'(0));
    tick();

    // Contention: dbus first (ibus served last), idle gap, then ibus
    expect_txn(1'b0, 6'h22, 32'hCAFE_F00D, 4'hC, 1'b0, 2, 32'hD0D0_0001, 32'hD0D0_0001, 1'b0);
    expect_txn(1'b1, 6'h11, 32'h0, 4'hF, 1'b0, 3, 32'h1B1B_0002, 32'h1B1B_0002, 1'b0);
    bus.i_ibus_adr = 6'h11;
    bus.i_ibus_cyc = 1'b1;
    set_dbus(6'h22, 32'hCAFE_F00D, 4'hC, 1'b0, 1'b1);
    wait_ack(1'b1, "t2_d", 3);
    bus.i_dbus_cyc = 1'b0;
    #2;
    check("t2_gap_stb", 64'(bus.o_wb_stb), 64'(0));
    wait_ack(1'b0, "t2_i", 4);

    // Repeat contention right away: ibus was last, so dbus again
    expect_txn(1'b0, 6'h23, 32'h0000_0042, 4'hF, 1'b0, 1, 32'h0000_0033, 32'h0000_0033, 1'b0);
    set_dbus(6'h23, 32'h0000_0042, 4'hF, 1'b0, 1'b1);
    wait_ack(1'b1, "t2_rr", 2);
    bus.i_ibus_cyc = 1'b0;
    bus.i_dbus_cyc = 1'b0;
    tick();
    #2;
    check("t2_rr_quiet", 64'(bus.o_wb_stb), 64'(0));
    tick();

    // dbus partial write to top word
    expect_txn(1'b0, 6'h3F, 32'hA5A5_A5A5, 4'b0101, 1'b1, 4, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
    set_dbus(6'h3F, 32'hA5A5_A5A5, 4'b0101, 1'b1, 1'b1);
    wait_ack(1'b1, "t3", 5);
    bus.i_dbus_cyc = 1'b0;
    tick();

    // Slave never acks: timeout on grant cycle 8 with zero data and error
    expect_txn(1'b0, 6'h0A, 32'h1111_2222, 4'hF, 1'b0, 0, 32'h0, 32'h0, 1'b1);
    set_dbus(6'h0A, 32'h1111_2222, 4'hF, 1'b0, 1'b1);
    wait_ack(1'b1, "t4", 9);
    bus.i_dbus_cyc = 1'b0;
    #2;
    check("t4_idle_stb", 64'(bus.o_wb_stb), 64'(0));
    tick();

    // Real ack in the terminal cycle: normal completion, no error
    expect_txn(1'b0, 6'h0B, 32'h3333_4444, 4'hF, 1'b0, 8, 32'h7777_8888, 32'h7777_8888, 1'b0);
    set_dbus(6'h0B, 32'h3333_4444, 4'hF, 1'b0, 1'b1);
    wait_ack(1'b1, "t4b", 9);
    bus.i_dbus_cyc = 1'b0;
    tick();

    // Reset during grant cycle 3 of an ibus read aborts it; dbus then wins contention
    expect_txn(1'b1, 6'h07, 32'h0, 4'hF, 1'b0, 0, 32'h0, 32'h0, 1'b0);
    bus.i_ibus_adr = 6'h07;
    bus.i_ibus_cyc = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    gq.delete();
    #2;
    check("t5_rst_stb",  64'(bus.o_wb_stb),   64'(0));
    check("t5_rst_iack", 64'(bus.o_ibus_ack), 64'(0));
    check("t5_rst_dack", 64'(bus.o_dbus_ack), 64'(0));
    tick();
    rst = 1'b0;
    expect_txn(1'b0, 6'h15, 32'h0, 4'hF, 1'b0, 2, 32'h5A5A_0001, 32'h5A5A_0001, 1'b0);
    expect_txn(1'b1, 6'h07, 32'h0, 4'hF, 1'b0, 1, 32'h5A5A_0002, 32'h5A5A_0002, 1'b0);
    set_dbus(6'h15, 32'h0, 4'hF, 1'b0, 1'b1);
    #2;
    check("t5_post_rst_stb", 64'(bus.o_wb_stb), 64'(0));
    wait_ack(1'b1, "t5_d", 3);
    bus.i_dbus_cyc = 1'b0;
    wait_ack(1'b0, "t5_i", 2);
    bus.i_ibus_cyc = 1'b0;

    repeat (3) tick();
    check("grant_queue_drained", 64'(gq.size()), 64'(0));
    check("resp_queue_drained",  64'(rq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
